// File: rtl/aes_dec_key_sched.sv
// AES-128 round-key scheduler for the inverse cipher: expands a cipher key one
// round per clock into an 11-entry store, then serves keys from round 10 down to 0.
module aes_dec_key_sched #(
  parameter int NROUNDS = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         key_load,
  input  logic [127:0] cipher_key,
  input  logic         next_rk,
  input  logic         rewind,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         last_rk,
  output logic         key_ready
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_EXPAND = 2'd1;
  localparam logic [1:0] ST_READY  = 2'd2;
  localparam logic [3:0] LAST_IDX  = 4'(NROUNDS);

  // Forward S-box, byte 0x00 in the top eight bits.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [10:0] base;
    base = {~b, 3'b000};
    return SBOX_TABLE[base +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] i);
    case (i)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  logic [1:0]   state_reg;
  logic [3:0]   cnt_reg;
  logic [127:0] work_reg;
  logic [127:0] rk [0:NROUNDS];
  logic [127:0] next_key;
  logic [31:0]  temp_word;
  logic         expanding;

  assign expanding = (state_reg == ST_EXPAND) && !key_load;

  // work_reg always holds rk[cnt-1], so the next round key needs no store read.
  always_comb begin
    temp_word        = sub_word({work_reg[23:0], work_reg[31:24]}) ^ {rcon(cnt_reg), 24'h0};
    next_key         = '0;
    next_key[127:96] = work_reg[127:96] ^ temp_word;
    next_key[95:64]  = work_reg[95:64]  ^ next_key[127:96];
    next_key[63:32]  = work_reg[63:32]  ^ next_key[95:64];
    next_key[31:0]   = work_reg[31:0]   ^ next_key[63:32];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 4'd0;
      work_reg  <= '0;
      key_ready <= 1'b0;
      round_idx <= 4'd0;
    end else if (key_load) begin
      state_reg <= ST_EXPAND;
      cnt_reg   <= 4'd1;
      work_reg  <= cipher_key;
      key_ready <= 1'b0;
    end else begin
      case (state_reg)
        ST_EXPAND: begin
          work_reg <= next_key;
          if (cnt_reg == LAST_IDX) begin
            state_reg <= ST_READY;
            key_ready <= 1'b1;
            round_idx <= LAST_IDX;
            cnt_reg   <= 4'd0;
          end else begin
            cnt_reg <= cnt_reg + 4'd1;
          end
        end
        ST_READY: begin
          if (rewind) begin
            round_idx <= LAST_IDX;
          end else if (next_rk) begin
            round_idx <= (round_idx == 4'd0) ? LAST_IDX : round_idx - 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  generate
    for (genvar gi = 0; gi <= NROUNDS; gi++) begin : g_store
      if (gi == 0) begin : g_entry0
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rk[gi] <= '0;
          end else if (key_load) begin
            rk[gi] <= cipher_key;
          end
        end
      end else begin : g_entry
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            rk[gi] <= '0;
          end else if (expanding && cnt_reg == 4'(gi)) begin
            rk[gi] <= next_key;
          end
        end
      end
    end
  endgenerate

  assign round_key = (round_idx <= LAST_IDX) ? rk[round_idx] : '0;
  assign last_rk   = key_ready & (round_idx == 4'd0);

endmodule

// File: tb/tb_aes_dec_key_sched.sv
// Self-checking bench for aes_dec_key_sched: FIPS-197 vectors plus random keys and
// random next_rk/rewind traffic against a word-oriented key-expansion model.
module tb_aes_dec_key_sched;

  logic         clk;
  logic         rst_n;
  logic         key_load;
  logic [127:0] cipher_key;
  logic         next_rk;
  logic         rewind;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         last_rk;
  logic         key_ready;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]   sb [256];
  logic [127:0] exp_rk [0:10];
  int           model_idx;

  aes_dec_key_sched #(.NROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .key_load   (key_load),
    .cipher_key (cipher_key),
    .next_rk    (next_rk),
    .rewind     (rewind),
    .round_key  (round_key),
    .round_idx  (round_idx),
    .last_rk    (last_rk),
    .key_ready  (key_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // S-box from its definition: multiplicative inverse in GF(2^8), then the affine map.
  task automatic build_sbox();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h01;
      for (int k = 0; k < 254; k++) inv = gmul(inv, 8'(x));
      sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  task automatic model_expand(input logic [127:0] k);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_idx"},  128'(round_idx), 128'(model_idx));
    check({tag, "_key"},  round_key, exp_rk[model_idx]);
    check({tag, "_last"}, 128'(last_rk), 128'(model_idx == 0));
    $display("step %s: idx=%0d key=%h last=%0b", tag, round_idx, round_key, last_rk);
  endtask

  // Called at a negedge; returns at the negedge after the clocked edge.
  task automatic step(input logic n, input logic r);
    next_rk = n;
    rewind  = r;
    @(negedge clk);
    next_rk = 1'b0;
    rewind  = 1'b0;
    if (r) model_idx = 10;
    else if (n) model_idx = (model_idx == 0) ? 10 : model_idx - 1;
  endtask

  task automatic load_key(input logic [127:0] k, input bit noisy);
    int edges;
    key_load   = 1'b1;
    cipher_key = k;
    next_rk    = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    rewind     = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
    @(negedge clk);
    key_load = 1'b0;
    edges    = 1;
    while (!key_ready && edges < 40) begin
      next_rk = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      rewind  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      @(negedge clk);
      edges++;
    end
    next_rk = 1'b0;
    rewind  = 1'b0;
    model_expand(k);
    model_idx = 10;
    check("load_latency", 128'(edges), 128'(11));
    check("key_ready", 128'(key_ready), 128'(1));
    check_outputs("ready");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] ka;
    rst_n = 1'b0; key_load = 1'b0; cipher_key = '0; next_rk = 1'b0; rewind = 1'b0;
    build_sbox();
    #2;
    check("rst_ready", 128'(key_ready), 128'(0));
    check("rst_idx",   128'(round_idx), 128'(0));
    check("rst_key",   round_key, 128'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 Appendix A.1 key, walked down to round 0 and wrapped.
    load_key(128'h2b7e151628aed2a6abf7158809cf4f3c, 1'b0);
    check("fips_rk10", round_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    repeat (9) step(1'b1, 1'b0);
    check_outputs("fips_r1");
    check("fips_rk1", round_key, 128'ha0fafe1788542cb123a339392a6c7605);
    step(1'b1, 1'b0);
    check_outputs("fips_r0");
    check("fips_rk0", round_key, 128'h2b7e151628aed2a6abf7158809cf4f3c);
    step(1'b1, 1'b0);
    check_outputs("wrap");

    load_key(128'h000102030405060708090a0b0c0d0e0f, 1'b0);
    check("vec2_rk10", round_key, 128'h13111d7fe3944a17f307a78b4d2b30c5);
    repeat (5) step(1'b1, 1'b0);
    check_outputs("at5");
    step(1'b1, 1'b1);
    check_outputs("rewind_wins");

    // Asynchronous reset mid-cycle, no clock edge in between.
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_ready", 128'(key_ready), 128'(0));
    check("arst_idx",   128'(round_idx), 128'(0));
    check("arst_key",   round_key, 128'(0));
    check("arst_last",  128'(last_rk), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(1'b1, 1'b1);
    check("idle_ignore", 128'(key_ready), 128'(0));

    // Reset during expansion abandons the key.
    key_load = 1'b1; cipher_key = 128'(ka);
    @(negedge clk);
    key_load = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("expand_reset", 128'(key_ready), 128'(0));

    // Restart: key B loaded 4 cycles into key A's expansion, next_rk held high meanwhile.
    ka = {$urandom, $urandom, $urandom, $urandom};
    key_load = 1'b1; cipher_key = ka;
    @(negedge clk);
    key_load = 1'b0;
    repeat (4) begin
      next_rk = 1'b1;
      @(negedge clk);
    end
    next_rk = 1'b0;
    load_key({$urandom, $urandom, $urandom, $urandom}, 1'b0);

    // Random keys with random traffic during and after expansion.
    for (int k = 0; k < 4; k++) begin
      load_key({$urandom, $urandom, $urandom, $urandom}, 1'b1);
      for (int s = 0; s < 25; s++) begin
        step(1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0));
        check_outputs("rand");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_dec_key_sched.md
Name: aes_dec_key_sched

Overview:
AES-128 round-key scheduler that sits directly upstream of the decryption round datapath and drives its key_in. It expands a 128-bit cipher key iteratively, one round key per clock, into an 11-entry key store. It then presents the round keys in reverse order (round 10 down to round 0), one per next_rk request, as the inverse cipher requires. The key store is reusable for any number of blocks until a new key is loaded.

Parameters:
NROUNDS, 10, number of AES rounds; the key store holds NROUNDS+1 entries. Only 10 (AES-128) is supported.

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
key_load  input  1  single-cycle pulse that captures cipher_key and starts expansion
cipher_key  input  128  AES-128 cipher key, sampled when key_load=1
next_rk  input  1  advance to the next (lower) round key; honoured only in READY
rewind  input  1  reset the read pointer to round NROUNDS; honoured only in READY
round_key  output  128  round key currently selected by the read pointer (to key_in of the round stage)
round_idx  output  4  index of round_key (10..0)
last_rk  output  1  high when round_idx==0
key_ready  output  1  key store valid; round_key is meaningful

Behaviour:
- Single clock domain. rst_n is asynchronous assert and synchronous-to-clk deassert, applied externally.
- Reset values:
  - state=IDLE
  - key_ready=0
  - round_idx=0
  - last_rk=0
  - round_key=0
  - internal expansion counter cnt=0
  - key store cleared to 0
- FSM states: IDLE, EXPAND, READY.
  - IDLE: waits for key_load.
  - key_load=1 in any state, sampled at edge T:
    - rk[0]<=cipher_key, cnt<=1, state<=EXPAND, key_ready<=0.
    - key_load has priority over next_rk and rewind in the same cycle.
  - EXPAND: at each edge T+1..T+10, rk[cnt] is computed from rk[cnt-1], then cnt increments.
    - Word rule: w0'=w0^SubWord(RotWord(w3))^{rcon[cnt],24'h0}, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
    - w0 is bits [127:96].
    - RotWord rotates bytes left by one.
    - SubWord applies the forward AES S-box to each byte, through a combinational lookup table.
    - rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36.
  - At edge T+10, when rk[10] is written: state<=READY, key_ready<=1, round_idx<=10. key_ready is therefore first high in the cycle after edge T+10, an 11-edge load-to-ready latency.
  - READY: round_key = rk[round_idx], driven combinationally from the store.
    - next_rk=1: round_idx decrements. When round_idx==0, next_rk wraps round_idx to 10 for the next block.
    - rewind=1: round_idx<=10. If next_rk and rewind are both high, rewind wins.
- last_rk = key_ready & (round_idx==0).
- next_rk and rewind are ignored in IDLE and EXPAND.
- key_load mid-EXPAND restarts expansion from the new key. Partially computed entries are overwritten, and there is no merge with old keys.
- key_load in READY drops key_ready the following cycle. round_key is don't-care until key_ready returns.
- Reset mid-EXPAND: returns to IDLE immediately and the key must be reloaded.
- No backpressure: the consumer may issue next_rk every cycle.

Test Plan:
- Reset check: assert rst_n=0 mid-cycle -> outputs go to 0 asynchronously, without waiting for a clock edge: key_ready=0, round_idx=0, round_key=0.
- FIPS-197 key expansion:
  - Stimulus: key_load with cipher_key=2b7e151628aed2a6abf7158809cf4f3c.
  - key_ready rises exactly 11 edges later, with round_idx=10 and round_key=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - Issue next_rk 9 times -> round_idx=1, round_key=a0fafe1788542cb123a339392a6c7605.
  - Issue one more next_rk -> round_idx=0, round_key=the cipher key, last_rk=1.
- Second vector: key 000102030405060708090a0b0c0d0e0f -> at ready, round_key=13111d7fe3944a17f307a78b4d2b30c5.
- Wrap and rewind:
  - At round_idx=0, next_rk -> round_idx=10, last_rk=0.
  - At round_idx=5, assert next_rk and rewind together -> round_idx=10.
- Restart and ignore rules:
  - key_load of key B 4 cycles into the expansion of key A -> key_ready follows 11 edges after B's load, and the round 10 key is B's.
  - next_rk pulses issued during EXPAND have no effect.
